// File: rtl/video_dither_pkg.sv
// Shared constants for the ordered/temporal/error-diffusion dither pipeline.
package video_dither_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'b00,
        MODE_ORDERED  = 2'b01,
        MODE_TEMPORAL = 2'b10,
        MODE_ERRDIFF  = 2'b11
    } mode_e;

    localparam logic [3:0] BAYER [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    // Bayer entry scaled down to the D bits being discarded.
    function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x,
                                             input int unsigned d);
        return BAYER[y][x] >> (4 - d);
    endfunction

endpackage

// File: rtl/video_dither_channel.sv
// One colour component: threshold/error add, then shift, saturate and blank.
// VIDEO_DITHER_ERRDIFF_EN adds the per-component error register for mode 11.
module video_dither_channel
    import video_dither_pkg::*;
#(
    parameter int unsigned INBITS  = 8,
    parameter int unsigned OUTBITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ena,
    input  logic [1:0]         sel,
    input  logic [3:0]         thr,
    input  logic [INBITS-1:0]  pix_in,
    output logic [OUTBITS-1:0] pix_out
);
    localparam int unsigned D = INBITS - OUTBITS;

    logic [INBITS:0]    sum_d;
    logic [INBITS:0]    thr_ext;
    logic [OUTBITS:0]   hi_q;
    logic               ena_q;
    logic [OUTBITS-1:0] out_d;

    always_comb thr_ext = {{(INBITS - 3){1'b0}}, thr};

`ifdef VIDEO_DITHER_ERRDIFF_EN
    logic [D-1:0] err_q;
    logic [D-1:0] err_d;

    always_comb begin
        sum_d = {1'b0, pix_in};
        if (sel == MODE_ERRDIFF) begin
            sum_d = {1'b0, pix_in} + {{(INBITS + 1 - D){1'b0}}, err_q};
        end else if (sel != MODE_TRUNC) begin
            sum_d = {1'b0, pix_in} + thr_ext;
        end
        // Saturated pixels carry no residue; blanking restarts each line at zero.
        err_d = '0;
        if (ena && sel == MODE_ERRDIFF && !sum_d[INBITS]) begin
            err_d = sum_d[D-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_residue;

    always_comb begin
        sum_d = {1'b0, pix_in};
        if (sel != MODE_TRUNC) begin
            sum_d = {1'b0, pix_in} + thr_ext;
        end
    end

    assign unused_residue = ^sum_d[D-1:0];
`endif

    always_comb begin
        out_d = hi_q[OUTBITS] ? '1 : hi_q[OUTBITS-1:0];
        if (!ena_q) begin
            out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            ena_q   <= 1'b0;
            pix_out <= '0;
        end else begin
            hi_q    <= sum_d[INBITS:D];
            ena_q   <= ena;
            pix_out <= out_d;
        end
    end

endmodule

// File: rtl/video_dither_ordered.sv
// Multi-channel dither stage with 2-cycle pixel/sync latency.
// VIDEO_DITHER_ERRDIFF_EN enables error diffusion in mode 11 (else mode 11 = mode 10).
module video_dither_ordered
    import video_dither_pkg::*;
#(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned INBITS          = 8,
    parameter int unsigned OUTBITS         = 4,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic                         vid_ena,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*INBITS-1:0]   pix_in,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         ena_out,
    output logic [CHANNELS*OUTBITS-1:0]  pix_out
);
    localparam int unsigned D         = INBITS - OUTBITS;
    localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic       vs_act;
    logic       vs_act_q;
    logic       vs_lead;
    logic [1:0] x_q;
    logic [1:0] y_q;
    logic [1:0] frame_q;
    logic [1:0] mode_q;
    logic [1:0] mode_eff;
    logic [1:0] x_eff;
    logic [3:0] thr;
    logic [1:0] hs_q;
    logic [1:0] vs_q;
    logic [1:0] en_q;

    always_comb begin
        vs_act   = SYNC_IDLE ? ~vsync : vsync;
        vs_lead  = vs_act & ~vs_act_q;
        mode_eff = mode_q;
`ifndef VIDEO_DITHER_ERRDIFF_EN
        if (mode_q == MODE_ERRDIFF) begin
            mode_eff = MODE_TEMPORAL;
        end
`endif
        x_eff = (mode_eff == MODE_ORDERED) ? x_q : x_q + frame_q;
        thr   = bayer_thr(y_q, x_eff, D);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_act_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            mode_q   <= MODE_TRUNC;
            hs_q     <= {2{SYNC_IDLE}};
            vs_q     <= {2{SYNC_IDLE}};
            en_q     <= '0;
        end else begin
            vs_act_q <= vs_act;
            x_q      <= vid_ena ? x_q + 2'd1 : 2'd0;
            // Mode changes only land on a frame boundary.
            if (vs_lead) begin
                y_q     <= '0;
                frame_q <= frame_q + 2'd1;
                mode_q  <= mode;
            end else if (en_q[0] && !vid_ena) begin
                y_q <= y_q + 2'd1;
            end
            hs_q <= {hs_q[0], hsync};
            vs_q <= {vs_q[0], vsync};
            en_q <= {en_q[0], vid_ena};
        end
    end

    assign hsync_out = hs_q[1];
    assign vsync_out = vs_q[1];
    assign ena_out   = en_q[1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        video_dither_channel #(
            .INBITS  (INBITS),
            .OUTBITS (OUTBITS)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .ena     (vid_ena),
            .sel     (mode_eff),
            .thr     (thr),
            .pix_in  (pix_in[c*INBITS +: INBITS]),
            .pix_out (pix_out[c*OUTBITS +: OUTBITS])
        );
    end

endmodule

// File: tb/tb_video_dither_ordered.sv
// Randomised and directed bench for video_dither_ordered against a per-pixel reference model.
module tb_video_dither_ordered;

    typedef struct packed {
        logic [11:0] pix;
        logic        ena;
        logic        hs;
        logic        vs;
    } exp_t;

    localparam int BAYER_T [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        vid_ena = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [23:0] pix_in = '0;
    logic        hsync_out;
    logic        vsync_out;
    logic        ena_out;
    logic [11:0] pix_out;

    int total = 0;
    int bad = 0;

    int m_x, m_y, m_frame, m_mode;
    int m_err [3];
    bit m_vs_prev, m_ena_prev;
    exp_t        exp_q[$];
    logic [11:0] obs_q[$];

    always #5 clk = ~clk;

    video_dither_ordered #(
        .CHANNELS        (3),
        .INBITS          (8),
        .OUTBITS         (4),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hsync     (hsync),
        .vsync     (vsync),
        .vid_ena   (vid_ena),
        .mode      (mode),
        .pix_in    (pix_in),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .ena_out   (ena_out),
        .pix_out   (pix_out)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_frame = 0; m_mode = 0;
        m_vs_prev = 0; m_ena_prev = 0;
        for (int c = 0; c < 3; c++) m_err[c] = 0;
        exp_q.delete();
    endtask

    // Apply one pixel's worth of rules to the model and queue its expected output.
    task automatic model_step(input logic hs, input logic vs, input logic en,
                              input logic [1:0] md, input logic [23:0] px);
        exp_t e;
        int   eff, xe, thr, in, sum, q;
        bit   lead;
        eff = m_mode;
`ifndef VIDEO_DITHER_ERRDIFF_EN
        if (eff == 3) eff = 2;
`endif
        xe  = (eff == 1) ? m_x : (m_x + m_frame) % 4;
        thr = BAYER_T[m_y * 4 + xe];
        e.pix = '0;
        for (int c = 0; c < 3; c++) begin
            in = int'(px[c*8 +: 8]);
            case (eff)
                0:       sum = in;
                3:       sum = in + m_err[c];
                default: sum = in + thr;
            endcase
            q = sum / 16;
            if (q > 15) begin
                q = 15;
                m_err[c] = 0;
            end else begin
                m_err[c] = (eff == 3) ? sum % 16 : 0;
            end
            if (!en) m_err[c] = 0;
            if (en) e.pix[c*4 +: 4] = 4'(q);
        end
        e.ena = en; e.hs = hs; e.vs = vs;
        exp_q.push_back(e);

        lead = !vs && !m_vs_prev;
        m_vs_prev = !vs;
        m_x = en ? (m_x + 1) % 4 : 0;
        if (lead) begin
            m_y = 0;
            m_frame = (m_frame + 1) % 4;
            m_mode = int'(md);
        end else if (m_ena_prev && !en) begin
            m_y = (m_y + 1) % 4;
        end
        m_ena_prev = en;
    endtask

    task automatic cycle(input logic hs, input logic vs, input logic en, input logic [23:0] px);
        exp_t e;
        hsync = hs; vsync = vs; vid_ena = en; pix_in = px;
        model_step(hs, vs, en, mode, px);
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_eq("pix_out", int'(pix_out), int'(e.pix));
            check_eq("ena_out", int'(ena_out), int'(e.ena));
            check_eq("hsync_out", int'(hsync_out), int'(e.hs));
            check_eq("vsync_out", int'(vsync_out), int'(e.vs));
            if (ena_out) obs_q.push_back(pix_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic frame_start(input logic [1:0] md);
        mode = md;
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        cycle(1'b1, 1'b0, 1'b0, 24'h0);
        idle(1);
    endtask

    task automatic line(input int n, input logic [23:0] px);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, px);
        cycle(1'b0, 1'b1, 1'b0, 24'h0);
        cycle(1'b0, 1'b1, 1'b0, 24'h0);
        idle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pix"}, int'(pix_out), 0);
        check_eq({tag, "_ena"}, int'(ena_out), 0);
        check_eq({tag, "_hs"}, int'(hsync_out), 1);
        check_eq({tag, "_vs"}, int'(vsync_out), 1);
    endtask

    initial begin
        int ones;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Truncate after reset, 0xAB -> 0xA on every component.
        obs_q.delete();
        line(4, 24'hABABAB);
        idle(2);
        check_eq("trunc_n", obs_q.size(), 4);
        if (obs_q.size() > 0) check_eq("trunc_ab", int'(obs_q[0]), 12'hAAA);

        // Ordered: flat 0x08 over a 4x4 block lights exactly half.
        frame_start(2'b01);
        obs_q.delete();
        for (int l = 0; l < 4; l++) line(4, 24'h080808);
        idle(2);
        check_eq("ord_n", obs_q.size(), 16);
        ones = 0;
        foreach (obs_q[i]) ones += int'(obs_q[i][3:0]);
        check_eq("ord_ones", ones, 8);
        if (obs_q.size() >= 2) begin
            check_eq("ord_x0y0", int'(obs_q[0][3:0]), 0);
            check_eq("ord_x1y0", int'(obs_q[1][3:0]), 1);
        end

        // Full scale must saturate rather than wrap.
        obs_q.delete();
        line(4, 24'hFFFFFF);
        idle(2);
        foreach (obs_q[i]) check_eq("ord_sat", int'(obs_q[i]), 12'hFFF);

        // Temporal: pixel (0,0) across four frames alternates.
        obs_q.delete();
        for (int f = 0; f < 4; f++) begin
            frame_start(2'b10);
            line(1, 24'h080808);
        end
        idle(2);
        check_eq("tmp_n", obs_q.size(), 4);
        ones = 0;
        foreach (obs_q[i]) ones += int'(obs_q[i][3:0]);
        check_eq("tmp_ones", ones, 2);
        if (obs_q.size() >= 2) check_eq("tmp_alt", int'(obs_q[0] != obs_q[1]), 1);

        // Mode 11: diffusion when built in, otherwise temporal (model covers both).
        frame_start(2'b11);
        obs_q.delete();
        line(8, 24'h080808);
        line(1, 24'h080808);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, (i == 0) ? 24'h080808 :
                                          (i == 1) ? 24'hFFFFFF : 24'h0A0A0A);
        idle(3);
`ifdef VIDEO_DITHER_ERRDIFF_EN
        check_eq("ed_n", obs_q.size(), 13);
        if (obs_q.size() >= 13) begin
            for (int i = 0; i < 8; i++) check_eq("ed_line", int'(obs_q[i][3:0]), i % 2);
            check_eq("ed_newline", int'(obs_q[8][3:0]), 0);
            check_eq("ed_sat", int'(obs_q[10]), 12'hFFF);
            check_eq("ed_clr0", int'(obs_q[11][3:0]), 0);
            check_eq("ed_clr1", int'(obs_q[12][3:0]), 1);
        end
`endif

        // Randomised traffic including random vsync edges and mode changes.
        for (int i = 0; i < 1500; i++) begin
            mode = 2'($urandom_range(0, 3));
            cycle(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 15) != 0),
                  logic'($urandom_range(0, 3) != 0), 24'($urandom));
        end
        idle(2);

        // Asynchronous reset in the middle of a line.
        frame_start(2'b01);
        cycle(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        cycle(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        cycle(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        hsync = 1'b1; vsync = 1'b1; vid_ena = 1'b0;
        model_reset();
        mode = 2'b01;
        @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        line(4, 24'h080808);
        idle(2);
        check_eq("post_rst_n", obs_q.size(), 4);
        foreach (obs_q[i]) check_eq("post_rst_trunc", int'(obs_q[i]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
